// File: rtl/kalman_sched.sv
// Round-robin scheduler sharing one Kalman filter core among N_CH sample streams.
// One sample is buffered per channel. A watchdog aborts transactions when the core hangs.
`timescale 1ns/1ps
module kalman_sched #(
  parameter int N_CH    = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64,
  localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    ch_en,
  input  logic [N_CH-1:0]    in_valid,
  input  logic [N_CH*DW-1:0] in_data,
  output logic [N_CH-1:0]    in_ready,
  output logic               core_start,
  output logic [CW-1:0]      core_ch,
  output logic [DW-1:0]      core_data,
  input  logic               core_done,
  input  logic [DW-1:0]      core_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [CW-1:0]      out_ch,
  output logic               err_pulse,
  output logic [7:0]         err_cnt
);

  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t          state, state_nxt;
  logic [N_CH-1:0] buf_full;
  logic [DW-1:0]   buf_data [N_CH];
  logic [N_CH-1:0] req;
  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   arb_gnt;
  logic [CW-1:0]   arb_idx;
  logic            arb_hit;
  logic [WDW-1:0]  wd;
  logic            timeout_hit;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign req      = buf_full & ch_en;
  assign in_ready = ch_en & ~buf_full;

  // Search starts one past the last served channel, so it always comes last.
  always_comb begin
    arb_hit = 1'b0;
    arb_gnt = '0;
    arb_idx = '0;
    for (int k = 1; k <= N_CH; k++) begin
      arb_idx = CW'((int'(rr_ptr) + k) % N_CH);
      if (!arb_hit && req[arb_idx]) begin
        arb_hit = 1'b1;
        arb_gnt = arb_idx;
      end
    end
  end

  // core_done takes priority over an expiring watchdog in the same cycle.
  assign timeout_hit = (state == WAIT) && !core_done && (wd == WDW'(TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    out_valid  = 1'b0;
    err_pulse  = 1'b0;
    case (state)
      IDLE:  if (arb_hit) state_nxt = ISSUE;
      ISSUE: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          state_nxt = OUT;
        end else if (timeout_hit) begin
          err_pulse = 1'b1;
          state_nxt = IDLE;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= CW'(N_CH - 1);
      buf_full  <= '0;
      wd        <= '0;
      core_ch   <= '0;
      core_data <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      err_cnt   <= '0;
    end else begin
      state <= state_nxt;
      for (int i = 0; i < N_CH; i++) begin
        if (!ch_en[i])                                buf_full[i] <= 1'b0;
        else if (in_valid[i] && in_ready[i])          buf_full[i] <= 1'b1;
        else if (state == ISSUE && core_ch == CW'(i)) buf_full[i] <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (arb_hit) begin
            core_ch   <= arb_gnt;
            core_data <= buf_data[arb_gnt];
          end
        end
        ISSUE: wd <= '0;
        WAIT: begin
          if (core_done) begin
            out_data <= core_result;
            out_ch   <= core_ch;
          end else if (timeout_hit) begin
            rr_ptr  <= core_ch;
            err_cnt <= sat_inc8(err_cnt);
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        OUT: if (out_ready) rr_ptr <= core_ch;
        default: ;
      endcase
    end
  end

  // Sample storage carries no reset; buf_full alone qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (in_valid[i] && in_ready[i]) buf_data[i] <= in_data[i*DW +: DW];
    end
  end

endmodule

// File: tb/tb_kalman_sched.sv
// Scoreboard bench for kalman_sched: directed stimulus pushes expected results,
// a negedge monitor pops and compares every output beat; a core model answers starts.
`timescale 1ns/1ps
module tb_kalman_sched;
  localparam int N_CH = 4;
  localparam int DW = 32;
  localparam int TIMEOUT = 8;
  localparam int CW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_CH-1:0]    ch_en, in_valid, in_ready;
  logic [N_CH*DW-1:0] in_data;
  logic               core_start;
  logic [CW-1:0]      core_ch;
  logic [DW-1:0]      core_data;
  logic               core_done, model_done, stray_done;
  logic [DW-1:0]      core_result;
  logic               out_valid, out_ready;
  logic [DW-1:0]      out_data;
  logic [CW-1:0]      out_ch;
  logic               err_pulse;
  logic [7:0]         err_cnt;

  assign core_done = model_done | stray_done;

  kalman_sched #(.N_CH(N_CH), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .core_start(core_start), .core_ch(core_ch),
    .core_data(core_data), .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_done_cyc = -10;
  int   n_out = 0;
  int   core_lat = 3;
  bit   core_hang = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int ch, input logic [DW-1:0] d);
    exp_t e;
    e.ch   = CW'(ch);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic set_in(input int ch, input logic [DW-1:0] d);
    in_data[ch*DW +: DW] = d;
  endtask

  task automatic wait_start(input string name, input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (core_start) seen = 1'b1;
    end
    chk(name, seen, 1);
  endtask

  task automatic wait_ov(input string name, input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk(name, seen, 1);
  endtask

  task automatic wait_drain(input string name, input int lim);
    bit done = 1'b0;
    for (int i = 0; i < lim && !done; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    chk(name, done, 1);
    #1;
  endtask

  task automatic wait_nout(input string name, input int tgt, input int lim);
    bit done = 1'b0;
    for (int i = 0; i < lim && !done; i++) begin
      @(posedge clk);
      if (n_out >= tgt) done = 1'b1;
    end
    chk(name, done, 1);
  endtask

  // Core model: result is the sample halved, returned core_lat cycles after start.
  initial begin
    logic [DW-1:0] d;
    model_done  = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (core_start && !core_hang) begin
        d = core_data;
        repeat (core_lat) @(posedge clk);
        #1;
        chk("core_data_held", core_data, d);
        model_done    = 1'b1;
        core_result   = d >> 1;
        last_done_cyc = cyc;
        @(posedge clk);
        #1 model_done = 1'b0;
      end
    end
  end

  // Monitor: every accepted output beat must match the head of the scoreboard.
  initial begin
    exp_t e;
    bit   prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_ov) chk("out_valid_latency", cyc, last_done_cyc + 1);
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got ch %0d data 0x%08h expected no beat", out_ch, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_ch", out_ch, e.ch);
          chk("out_data", out_data, e.data);
        end
        n_out++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int npulse;
    rst        = 1'b1;
    ch_en      = '1;
    in_valid   = '0;
    in_data    = '0;
    out_ready  = 1'b1;
    stray_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 4'hF);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_ch", core_ch, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // Single channel, core latency 3
    @(posedge clk); #1;
    set_in(0, 32'h0001_0000);
    in_valid = 4'b0001;
    push_exp(0, 32'h0000_8000);
    @(negedge clk);
    chk("p1_accept", in_ready[0], 1);
    @(posedge clk); #1 in_valid = '0;
    @(negedge clk);
    chk("p1_start_T1", core_start, 0);
    @(negedge clk);
    chk("p1_start_T2", core_start, 1);
    chk("p1_core_ch", core_ch, 0);
    chk("p1_core_data", core_data, 32'h0001_0000);
    chk("p1_ready_in_issue", in_ready[0], 0);
    @(negedge clk);
    chk("p1_ready_after_issue", in_ready[0], 1);
    chk("p1_start_pulse_len", core_start, 0);
    wait_drain("p1_drain", 40);

    // Fairness: all channels valid continuously, latency 1; last served was ch0
    core_lat = 1;
    set_in(0, 32'h0004_0000);
    set_in(1, 32'h0006_0000);
    set_in(2, 32'h000A_0000);
    set_in(3, 32'h0010_0000);
    in_valid = '1;
    for (int r = 0; r < 2; r++) begin
      push_exp(1, 32'h0003_0000);
      push_exp(2, 32'h0005_0000);
      push_exp(3, 32'h0008_0000);
      push_exp(0, 32'h0002_0000);
    end
    wait_nout("fair_outputs", n_out + 8, 200);
    #1;
    ch_en    = '0;
    in_valid = '0;
    @(posedge clk); #1 ch_en = '1;
    @(negedge clk);
    chk("fair_flushed_ready", in_ready, 4'hF);
    chk("fair_no_start", core_start, 0);

    // Backpressure: ch1 and ch2 pending, output stalled
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_in(1, 32'h0000_4000);
    set_in(2, 32'h0003_0000);
    in_valid = 4'b0110;
    push_exp(1, 32'h0000_2000);
    push_exp(2, 32'h0001_8000);
    @(posedge clk); #1 in_valid = '0;
    wait_ov("bp_out_valid", 40);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_ch", out_ch, 1);
      chk("bp_hold_data", out_data, 32'h0000_2000);
      chk("bp_no_start", core_start, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_start("bp_next_start", 20);
    chk("bp_next_ch", core_ch, 2);
    wait_drain("bp_drain", 40);

    // Watchdog: ch3 hangs and is dropped, ch0 granted next
    core_hang = 1'b1;
    set_in(3, 32'h1234_0000);
    set_in(0, 32'h0000_0002);
    in_valid = 4'b1001;
    push_exp(0, 32'h0000_0001);
    @(posedge clk); #1 in_valid = '0;
    wait_start("wd_start", 20);
    chk("wd_first_ch", core_ch, 3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("wd_err_pulse", err_pulse, (k == 8));
      chk("wd_no_out", out_valid, 0);
    end
    @(posedge clk); #1 core_hang = 1'b0;
    @(negedge clk);
    chk("wd_err_cnt", err_cnt, 1);
    chk("wd_pulse_once", err_pulse, 0);
    @(negedge clk);
    chk("wd_next_start", core_start, 1);
    chk("wd_next_ch", core_ch, 0);
    wait_drain("wd_drain", 40);

    // Saturation: 300 more timeouts on ch0
    core_hang = 1'b1;
    set_in(0, 32'h0000_AAAA);
    in_valid = 4'b0001;
    npulse = 0;
    for (int i = 0; i < 4000 && npulse < 300; i++) begin
      @(negedge clk);
      if (err_pulse) npulse++;
    end
    chk("sat_pulses", npulse, 300);
    @(posedge clk); #1;
    ch_en    = '0;
    in_valid = '0;
    @(negedge clk);
    chk("sat_err_cnt", err_cnt, 8'hFF);
    @(posedge clk); #1;
    ch_en     = '1;
    core_hang = 1'b0;

    // Disable: ch2 buffered while ch1 waits, then disabled
    core_lat = 6;
    set_in(1, 32'h0100_0000);
    in_valid = 4'b0010;
    push_exp(1, 32'h0080_0000);
    @(posedge clk); #1 in_valid = '0;
    wait_start("dis_start", 20);
    chk("dis_ch1", core_ch, 1);
    @(posedge clk); #1;
    set_in(2, 32'hDEAD_0000);
    in_valid = 4'b0100;
    @(negedge clk);
    chk("dis_ch2_accept", in_ready[2], 1);
    @(posedge clk); #1;
    in_valid = '0;
    ch_en[2] = 1'b0;
    @(negedge clk);
    chk("dis_ch2_ready_low", in_ready[2], 0);
    wait_drain("dis_drain", 40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("dis_no_grant", core_start, 0);
    end
    @(posedge clk); #1 ch_en[2] = 1'b1;
    @(negedge clk);
    chk("dis_reenable_ready", in_ready[2], 1);
    chk("dis_reenable_no_start", core_start, 0);
    @(negedge clk);
    chk("dis_buffer_cleared", core_start, 0);

    // Async reset during WAIT, then a stray core_done in IDLE
    core_hang = 1'b1;
    @(posedge clk); #1;
    set_in(1, 32'h0055_0000);
    in_valid = 4'b0010;
    @(posedge clk); #1 in_valid = '0;
    wait_start("ar_start", 20);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #2;
    chk("ar_core_start", core_start, 0);
    chk("ar_core_ch", core_ch, 0);
    chk("ar_core_data", core_data, 0);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data", out_data, 0);
    chk("ar_out_ch", out_ch, 0);
    chk("ar_err_cnt", err_cnt, 0);
    chk("ar_in_ready", in_ready, 4'hF);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ar_no_out", out_valid, 0);
      chk("ar_no_start", core_start, 0);
    end
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
